// File: rtl/maze_pkg.sv
// Shared definitions for the maze solver: direction encoding, FSM state
// codes and the opposite-direction helper.
package maze_pkg;

  localparam logic [1:0] DIR_N = 2'd0;  // y-1
  localparam logic [1:0] DIR_E = 2'd1;  // x+1
  localparam logic [1:0] DIR_S = 2'd2;  // y+1
  localparam logic [1:0] DIR_W = 2'd3;  // x-1

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_MARK      = 4'd1;
  localparam state_t ST_CHECK     = 4'd2;
  localparam state_t ST_PROBE     = 4'd3;
  localparam state_t ST_WAIT      = 4'd4;
  localparam state_t ST_ADVANCE   = 4'd5;
  localparam state_t ST_BACKTRACK = 4'd6;
  localparam state_t ST_REPLAY    = 4'd7;
  localparam state_t ST_DONE      = 4'd8;
  localparam state_t ST_FAIL      = 4'd9;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/maze_solver_ctrl_p_if.sv
// Maze-memory port and direction replay stream of the maze solver.
interface maze_solver_ctrl_p_if #(
  parameter int LOC_W = 8
) ();
  logic [LOC_W-1:0] mem_addr;
  logic             mem_rd;
  logic             mem_wr;
  logic             mem_wdata;
  logic             mem_rdata;
  logic             dir_valid;
  logic [1:0]       dir_out;
  logic             dir_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata, dir_valid, dir_out,
    input  mem_rdata, dir_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata, dir_valid, dir_out,
    output mem_rdata, dir_ready
  );
endinterface

// File: rtl/maze_dir_stack.sv
// LIFO of 2-bit move directions; top is the most recently pushed entry.
module maze_dir_stack #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] push_data,
  output logic [1:0] top,
  output logic       full,
  output logic       empty
);
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] sp_q, sp_d;
  logic [IDX_W-1:0] top_idx;
  logic [1:0]       mem_q [DEPTH];

  assign full    = (sp_q == PTR_W'(DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = IDX_W'(sp_q - PTR_W'(1));
  assign top     = mem_q[top_idx];

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sp_d = sp_q;
    if (clr)                sp_d = '0;
    else if (push && !full) sp_d = sp_q + PTR_W'(1);
    else if (pop && !empty) sp_d = sp_q - PTR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // NOTE: the entry storage is deliberately not reset; only the pointer defines which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem_q[sp_q[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/maze_solver_ctrl_p.sv
// Depth-first maze solver: marks visited cells in external memory, keeps the
// current path on a direction stack and replays the route DEST -> start.
module maze_solver_ctrl_p
  import maze_pkg::*;
#(
  parameter int                   COORD_W     = 4,
  parameter int                   STACK_DEPTH = 256,
  parameter logic [2*COORD_W-1:0] DEST        = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*COORD_W-1:0] start_loc,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic                 overflow,
  output logic [2*COORD_W:0]   path_len,
  maze_solver_ctrl_p_if.master bus
);
  localparam int LOC_W = 2 * COORD_W;
  localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);
  localparam logic [COORD_W-1:0] C_MAX = '1;
  localparam logic [LOC_W:0]     L_ONE = (LOC_W + 1)'(1);

  state_t           state_q, state_d;
  logic [LOC_W-1:0] cur_q, cur_d;
  logic [1:0]       dir_q, dir_d;
  logic [LOC_W:0]   path_len_q, path_len_d;
  logic             done_q, done_d, fail_q, fail_d, overflow_q, overflow_d;

  logic             stk_push, stk_pop, stk_clr, stk_full, stk_empty;
  logic [1:0]       stk_top;

  logic [1:0]       nb_dir;
  logic [LOC_W-1:0] nb_loc;
  logic             nb_off;
  logic [COORD_W-1:0] cx, cy;

  maze_dir_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (stk_clr),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (dir_q),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Backtracking walks back along the reverse of the popped move.
  assign nb_dir = (state_q == ST_BACKTRACK) ? opposite(stk_top) : dir_q;
  assign cx     = cur_q[COORD_W-1:0];
  assign cy     = cur_q[LOC_W-1:COORD_W];

  always_comb begin
    nb_loc = cur_q;
    nb_off = 1'b0;
    case (nb_dir)
      DIR_N:   begin nb_off = (cy == '0);   nb_loc = {cy - C_ONE, cx}; end
      DIR_E:   begin nb_off = (cx == C_MAX); nb_loc = {cy, cx + C_ONE}; end
      DIR_S:   begin nb_off = (cy == C_MAX); nb_loc = {cy + C_ONE, cx}; end
      default: begin nb_off = (cx == '0);   nb_loc = {cy, cx - C_ONE}; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    dir_d      = dir_q;
    path_len_d = path_len_q;
    done_d     = done_q;
    fail_d     = fail_q;
    overflow_d = overflow_q;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_clr    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        cur_d      = start_loc;
        dir_d      = DIR_N;
        path_len_d = '0;
        done_d     = 1'b0;
        fail_d     = 1'b0;
        overflow_d = 1'b0;
        stk_clr    = 1'b1;
        state_d    = ST_MARK;
      end
      ST_MARK:  state_d = ST_CHECK;
      ST_CHECK: state_d = (cur_q == DEST) ? ST_REPLAY : ST_PROBE;
      // An off-grid neighbour is resolved here as blocked, with no memory read.
      ST_PROBE: begin
        if (!nb_off)              state_d = ST_WAIT;
        else if (dir_q != DIR_W)  dir_d   = dir_q + 2'd1;
        else                      state_d = ST_BACKTRACK;
      end
      ST_WAIT: begin
        if (!bus.mem_rdata)       state_d = ST_ADVANCE;
        else if (dir_q != DIR_W) begin
          dir_d   = dir_q + 2'd1;
          state_d = ST_PROBE;
        end else                  state_d = ST_BACKTRACK;
      end
      ST_ADVANCE: begin
        if (stk_full) begin
          fail_d     = 1'b1;
          overflow_d = 1'b1;
          state_d    = ST_FAIL;
        end else begin
          stk_push   = 1'b1;
          cur_d      = nb_loc;
          dir_d      = DIR_N;
          path_len_d = path_len_q + L_ONE;
          state_d    = ST_MARK;
        end
      end
      ST_BACKTRACK: begin
        if (stk_empty) begin
          fail_d  = 1'b1;
          state_d = ST_FAIL;
        end else begin
          stk_pop    = 1'b1;
          cur_d      = nb_loc;
          path_len_d = path_len_q - L_ONE;
          if (stk_top != DIR_W) begin
            dir_d   = stk_top + 2'd1;
            state_d = ST_PROBE;
          end
        end
      end
      ST_REPLAY: begin
        if (stk_empty) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (bus.dir_ready) begin
          stk_pop = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      dir_q      <= DIR_N;
      path_len_q <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      dir_q      <= dir_d;
      path_len_q <= path_len_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.mem_wr    = (state_q == ST_MARK);
  assign bus.mem_wdata = (state_q == ST_MARK);
  assign bus.mem_rd    = (state_q == ST_PROBE) && !nb_off;
  assign bus.mem_addr  = bus.mem_wr ? cur_q : (bus.mem_rd ? nb_loc : '0);
  assign bus.dir_valid = (state_q == ST_REPLAY) && !stk_empty;
  assign bus.dir_out   = bus.dir_valid ? opposite(stk_top) : 2'b00;

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_FAIL);
  assign done     = done_q;
  assign fail     = fail_q;
  assign overflow = overflow_q;
  assign path_len = path_len_q;

endmodule

// File: tb/tb_maze_solver_ctrl_p.sv
// Directed bench for maze_solver_ctrl_p on a 4x4 grid with DEST = 4'hF.
module tb_maze_solver_ctrl_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_checks = 0;
  int n_err    = 0;

  // DUT A: default stack depth
  logic       start_a, rdy_a, rdata_a, ld_a, both_a;
  logic [3:0] start_loc_a;
  logic       busy_a, done_a, fail_a, ovf_a;
  logic [4:0] plen_a;
  logic [15:0] mem_a, init_a;
  int         wr_cnt_a [16];
  maze_solver_ctrl_p_if #(.LOC_W(4)) bus_a ();
  assign bus_a.mem_rdata = rdata_a;
  assign bus_a.dir_ready = rdy_a;

  maze_solver_ctrl_p #(.COORD_W(2), .STACK_DEPTH(256), .DEST(4'hF)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .start_loc(start_loc_a),
    .busy(busy_a), .done(done_a), .fail(fail_a), .overflow(ovf_a),
    .path_len(plen_a), .bus(bus_a)
  );

  // DUT B: two-entry stack
  logic       start_b, rdata_b, ld_b;
  logic [3:0] start_loc_b;
  logic       busy_b, done_b, fail_b, ovf_b;
  logic [4:0] plen_b;
  logic [15:0] mem_b;
  maze_solver_ctrl_p_if #(.LOC_W(4)) bus_b ();
  assign bus_b.mem_rdata = rdata_b;
  assign bus_b.dir_ready = 1'b1;

  maze_solver_ctrl_p #(.COORD_W(2), .STACK_DEPTH(2), .DEST(4'hF)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .start_loc(start_loc_b),
    .busy(busy_b), .done(done_b), .fail(fail_b), .overflow(ovf_b),
    .path_len(plen_b), .bus(bus_b)
  );

  // Maze memories: 1 = wall or visited, read data registered one cycle
  always @(posedge clk) begin
    if (ld_a) begin
      mem_a <= init_a;
      for (int i = 0; i < 16; i++) wr_cnt_a[i] <= 0;
    end else begin
      if (bus_a.mem_rd) rdata_a <= mem_a[bus_a.mem_addr];
      if (bus_a.mem_wr) begin
        mem_a[bus_a.mem_addr]    <= bus_a.mem_wdata;
        wr_cnt_a[bus_a.mem_addr] <= wr_cnt_a[bus_a.mem_addr] + 1;
      end
      if (bus_a.mem_rd && bus_a.mem_wr) both_a <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (ld_b) mem_b <= 16'h0000;
    else begin
      if (bus_b.mem_rd) rdata_b <= mem_b[bus_b.mem_addr];
      if (bus_b.mem_wr) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
    end
  end

  // Replay monitor for A, sampled mid-cycle
  logic [1:0] tok_a [$];
  int  valid_cyc_a, unstable_a, vld_idle_a;
  logic pv, pr;
  logic [1:0] pd;
  always @(negedge clk) begin
    if (!rst_n) pv = 1'b0;
    else begin
      if (bus_a.dir_valid) begin
        valid_cyc_a++;
        if (!busy_a) vld_idle_a++;
      end
      if (bus_a.dir_valid && bus_a.dir_ready) tok_a.push_back(bus_a.dir_out);
      if (pv && !pr && !(bus_a.dir_valid && bus_a.dir_out == pd)) unstable_a++;
      pv = bus_a.dir_valid;
      pr = bus_a.dir_ready;
      pd = bus_a.dir_out;
    end
  end

  // Ready driver: mode 0 always ready, mode 1 three stall cycles per token
  logic rdy_mode;
  int   hold;
  always @(posedge clk) begin
    #1;
    if (!rdy_mode) rdy_a = 1'b1;
    else if (bus_a.dir_valid) begin
      if (hold == 3) begin rdy_a = 1'b1; hold = 0; end
      else begin rdy_a = 1'b0; hold++; end
    end else begin
      rdy_a = 1'b0;
      hold  = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_tokens();
    logic [31:0] v = '0;
    foreach (tok_a[i]) v = (v << 2) | 32'(tok_a[i]);
    return v;
  endfunction

  task automatic clear_mon();
    tok_a.delete();
    valid_cyc_a = 0;
    unstable_a  = 0;
    vld_idle_a  = 0;
  endtask

  task automatic load_a(input logic [15:0] walls);
    @(posedge clk); #1;
    init_a = walls; ld_a = 1'b1;
    @(posedge clk); #1;
    ld_a = 1'b0;
    clear_mon();
  endtask

  task automatic go_a(input logic [3:0] loc);
    @(posedge clk); #1;
    start_loc_a = loc; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_end_a(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(done_a || fail_a) && n < 2000);
    check({tag, "_finish"}, 32'(n < 2000), 32'd1);
  endtask

  function automatic logic [31:0] outs_a();
    return 32'({busy_a, done_a, fail_a, ovf_a, bus_a.mem_rd, bus_a.mem_wr,
                bus_a.mem_wdata, bus_a.dir_valid, bus_a.dir_out, bus_a.mem_addr, plen_a});
  endfunction

  initial begin
    int n, tot, mx;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_loc_a = '0; start_loc_b = '0;
    ld_a = 1'b0; ld_b = 1'b0; both_a = 1'b0; init_a = '0; rdy_mode = 1'b0;
    hold = 0; rdy_a = 1'b1; pv = 1'b0; pr = 1'b0; pd = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset_outs_a", outs_a(), 32'd0);
    check("reset_outs_b", 32'({busy_b, done_b, fail_b, ovf_b, bus_b.mem_rd, bus_b.mem_wr,
                               bus_b.dir_valid, bus_b.mem_addr, plen_b}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Open grid from (0,0); a second start mid-solve must be ignored
    load_a(16'h0000);
    go_a(4'h0);
    @(negedge clk);
    check("open_busy", 32'(busy_a), 32'd1);
    repeat (4) @(posedge clk);
    #1 start_loc_a = 4'h5; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_end_a("open");
    check("open_done", 32'({done_a, fail_a, ovf_a, busy_a}), 32'b1000);
    check("open_path_len", 32'(plen_a), 32'd6);
    check("open_ntok", 32'(tok_a.size()), 32'd6);
    check("open_seq", pack_tokens(), 32'h03F);
    repeat (3) @(negedge clk);
    check("open_done_held", 32'({done_a, busy_a}), 32'b10);
    go_a(4'h0);
    @(negedge clk);
    check("restart_clears_done", 32'({done_a, busy_a}), 32'b01);
    wait_end_a("restart");

    // Start already at DEST
    load_a(16'h0000);
    go_a(4'hF);
    wait_end_a("dest");
    check("dest_done", 32'({done_a, fail_a}), 32'b10);
    check("dest_path_len", 32'(plen_a), 32'd0);
    check("dest_no_valid", 32'(valid_cyc_a), 32'd0);

    // (0,0) enclosed by walls at cells 1 and 4
    load_a(16'h0012);
    go_a(4'h0);
    wait_end_a("encl");
    check("encl_flags", 32'({done_a, fail_a, ovf_a, busy_a}), 32'b0100);
    check("encl_no_valid", 32'(valid_cyc_a), 32'd0);
    @(negedge clk);
    check("encl_idle_held", 32'({fail_a, busy_a}), 32'b10);

    // Dead end at (0,2) forces a two-level backtrack; walls 3,5,6,7
    load_a(16'h00E8);
    go_a(4'h0);
    wait_end_a("dead");
    check("dead_done", 32'({done_a, fail_a}), 32'b10);
    check("dead_path_len", 32'(plen_a), 32'd6);
    check("dead_seq", pack_tokens(), 32'h3F0);
    tot = 0; mx = 0;
    for (int i = 0; i < 16; i++) begin
      tot += wr_cnt_a[i];
      if (wr_cnt_a[i] > mx) mx = wr_cnt_a[i];
    end
    check("dead_writes_total", 32'(tot), 32'd9);
    check("dead_writes_max", 32'(mx), 32'd1);

    // Two-entry stack cannot hold a 6-move path
    @(posedge clk); #1 ld_b = 1'b1;
    @(posedge clk); #1 ld_b = 1'b0; start_loc_b = 4'h0; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(done_b || fail_b) && n < 2000);
    check("ovf_finish", 32'(n < 2000), 32'd1);
    check("ovf_flags", 32'({done_b, fail_b, ovf_b, busy_b}), 32'b0110);

    // Replay with three stall cycles per token
    rdy_mode = 1'b1;
    load_a(16'h0000);
    go_a(4'h0);
    wait_end_a("stall");
    check("stall_done", 32'(done_a), 32'd1);
    check("stall_ntok", 32'(tok_a.size()), 32'd6);
    check("stall_seq", pack_tokens(), 32'h03F);
    check("stall_stable", 32'(unstable_a), 32'd0);
    check("stall_valid_cycles", 32'(valid_cyc_a), 32'd24);

    // Reset while waiting on a memory read
    load_a(16'h0000);
    go_a(4'h0);
    n = 0;
    while (!bus_a.mem_rd && n < 200) begin @(negedge clk); n++; end
    check("rstw_reach_probe", 32'(bus_a.mem_rd), 32'd1);
    @(posedge clk); #1;
    check("rstw_busy_before", 32'(busy_a), 32'd1);
    rst_n = 1'b0; #1;
    check("rstw_outs", outs_a(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    load_a(16'h0000);
    go_a(4'h0);
    wait_end_a("rstw_fresh");
    check("rstw_fresh_path", 32'({done_a, plen_a}), 32'h26);

    // Reset while a replay token is stalled
    load_a(16'h0000);
    go_a(4'h0);
    n = 0;
    while (!bus_a.dir_valid && n < 500) begin @(negedge clk); n++; end
    check("rstr_reach_replay", 32'(bus_a.dir_valid), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0; #1;
    check("rstr_outs", outs_a(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    load_a(16'h0000);
    go_a(4'h0);
    wait_end_a("rstr_fresh");
    check("rstr_fresh_path", 32'({done_a, plen_a}), 32'h26);
    check("rstr_fresh_seq", pack_tokens(), 32'h03F);

    check("valid_only_busy", 32'(vld_idle_a), 32'd0);
    check("rd_wr_exclusive", 32'(both_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/maze_solver_ctrl_p.md
MAZE_SOLVER_CTRL_P -- requirements
Module: maze_solver_ctrl_p

Interface
REQ-001 Parameter COORD_W, default 4, meaning bits per coordinate; grid is 2^COORD_W x 2^COORD_W; location = {y,x}, width LOC_W = 2*COORD_W.
REQ-002 Parameter STACK_DEPTH, default 256, meaning maximum path length in moves.
REQ-003 Parameter DEST, default all ones (LOC_W bits), meaning target location.
REQ-004 clk  input  1  clock; all state updates on posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to begin solving; sampled only in IDLE.
REQ-007 start_loc  input  LOC_W  start location; captured when start is accepted.
REQ-008 mem_addr  output  LOC_W  maze memory address.
REQ-009 mem_rd / mem_wr  output  1 each  read / write strobes; never both high.
REQ-010 mem_wdata  output  1  write data; 1 = visited.
REQ-011 mem_rdata  input  1  read data, valid the cycle after mem_rd; 1 = wall or visited.
REQ-012 busy  output  1  high from start acceptance until DONE/FAIL.
REQ-013 done / fail / overflow  output  1 each  level status, held until next accepted start.
REQ-014 path_len  output  LOC_W+1  moves on the found path.
REQ-015 dir_valid / dir_out(2) / dir_ready  output/output/input  replay stream, valid-ready handshake.

Function
REQ-016 Directions: 0 = y-1, 1 = x+1, 2 = y+1, 3 = x-1; opposite(d) = d XOR 2'b10.
REQ-017 States: IDLE, MARK, CHECK, PROBE, WAIT, ADVANCE, BACKTRACK, REPLAY, DONE, FAIL.
REQ-018 IDLE: on start, load cur = start_loc, dir = 0, clear stack, path_len, done, fail, overflow; go to MARK.
REQ-019 MARK (1 cycle): mem_wr = 1, mem_addr = cur, mem_wdata = 1; go to CHECK.
REQ-020 CHECK: if cur == DEST go to REPLAY; else go to PROBE.
REQ-021 PROBE: if neighbour(cur,dir) leaves the grid (no wrap-around), treat as blocked without a memory access; else mem_rd = 1, mem_addr = neighbour; go to WAIT.
REQ-022 WAIT: if mem_rdata == 0 go to ADVANCE; if blocked and dir < 3, dir += 1, go to PROBE; if blocked and dir == 3, go to BACKTRACK.
REQ-023 ADVANCE: if stack full, set fail and overflow, go to FAIL; else push dir, cur = neighbour, dir = 0, path_len += 1, go to MARK.
REQ-024 BACKTRACK: if stack empty, set fail, go to FAIL; else pop d, cur = neighbour(cur,opposite(d)), path_len -= 1; if d == 3 stay in BACKTRACK, else dir = d+1 and go to PROBE.
REQ-025 REPLAY: while stack non-empty, dir_valid = 1, dir_out = opposite(top); pop only on dir_valid & dir_ready; stack empty -> DONE; emitted sequence is the route DEST -> start.
REQ-026 dir_out stable while dir_valid & !dir_ready; dir_valid never high outside REPLAY.
REQ-027 path_len holds the path length at REPLAY entry; replay pops do not change it.
REQ-028 DONE/FAIL: set done or fail, busy = 0, go to IDLE next cycle; status flags stay set.
REQ-029 start asserted while busy is ignored.
REQ-030 start_loc == DEST: MARK, CHECK, REPLAY with empty stack -> done, path_len = 0, no dir_valid.
REQ-031 mem_rd, mem_wr, dir_valid are registered-free Moore outputs of the state; no output depends combinationally on start.

Reset
REQ-032 rst_n low, at any time including mid-solve or mid-replay, forces IDLE, stack pointer 0, cur 0, dir 0, path_len 0, busy/done/fail/overflow/mem_rd/mem_wr/dir_valid 0, mem_addr 0, mem_wdata 0, dir_out 0.
REQ-033 Maze memory contents are not cleared by reset; clearing is the integrator's job.

Structure
REQ-034 Shared package maze_pkg holds direction encoding constants, opposite-direction function and the state enumeration.
REQ-035 Sub-module maze_dir_stack: LIFO, 2-bit entries, STACK_DEPTH deep, push/pop/top/full/empty, async active-low reset of pointer; simultaneous push and pop not used.
REQ-036 Neighbour/boundary logic is combinational inside maze_solver_ctrl_p.

Verification (COORD_W = 2, DEST = 4'hF)
REQ-037 Open 4x4 grid, start_loc 0 -> done, path_len 6, replay 6 directions all in {0,3} ending at (0,0).
REQ-038 Walls fully enclosing (0,0) -> fail = 1, overflow = 0, no dir_valid, busy low 1 cycle after FAIL.
REQ-039 Dead-end corridor forcing two-level backtrack -> correct path found, no cell written twice with mem_wr.
REQ-040 STACK_DEPTH = 2, path needs 6 moves -> fail = 1, overflow = 1.
REQ-041 Replay with dir_ready held low 3 cycles per token -> dir_out stable, no token lost or duplicated.
REQ-042 rst_n pulsed low during WAIT and during REPLAY -> all outputs at reset values that cycle; fresh start then solves normally.
